tl_ul_channel_buffer: RTL
=========================

// Module: tl_ul_channel_buffer
// PURPOSE
//  Parametrised TileLink-UL A/D channel buffer: the next step up from the
//  fixed-width, wire-only A/D pass-through slices between core and bus.
//  Inserts a configurable-depth FIFO on A (master->slave) and D (slave->master).
//  Tracks outstanding requests and throttles A at MAX_INFLIGHT.
//  Sits on the core-to-fabric port boundary to cut timing paths.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width; mask width = DATA_W/8
//  SOURCE_W      4   source/ID width
//  SIZE_W        4   size field width
//  A_DEPTH       2   A FIFO entries; 0 = combinational pass-through
//  D_DEPTH       2   D FIFO entries; 0 = combinational pass-through
//  PIPE          1   1: full FIFO may accept in the same cycle it dequeues
//  MAX_INFLIGHT  4   max A beats issued without a returned D beat (>=1)
// PORTS
//  clock         in   1     sole clock, rising edge
//  reset_n       in   1     synchronous, active-low reset
//  in_a_valid    in   1     upstream A valid
//  in_a_ready    out  1     upstream A ready
//  in_a_bits     in   AW    {opcode[2:0],param[2:0],size,source,address,mask,data,corrupt}
//  out_a_valid   out  1     downstream A valid
//  out_a_ready   in   1     downstream A ready
//  out_a_bits    out  AW    same packing as in_a_bits
//  in_d_valid    in   1     downstream D valid
//  in_d_ready    out  1     downstream D ready
//  in_d_bits     in   DW    {opcode[2:0],param[1:0],size,source,sink,denied,data,corrupt}
//  out_d_valid   out  1     upstream D valid
//  out_d_ready   in   1     upstream D ready
//  out_d_bits    out  DW    same packing as in_d_bits
//  inflight      out  CW    outstanding count, CW = $clog2(MAX_INFLIGHT+1)
//  a_full/d_full out  1     FIFO occupancy == depth (0 when depth 0)
// BEHAVIOUR
//  - Fire = valid & ready on the same port, same cycle. Bits sampled only on fire.
//  - Reset (reset_n=0 at posedge): wr/rd ptrs=0, counts=0, inflight=0.
//    Under reset, out_*_valid=0, in_*_ready=0. Stored data is don't-care.
//    Reset mid-transfer discards all buffered beats; no partial state survives.
//  - DEPTH>=1: circular buffer; ptrs wrap DEPTH-1 -> 0 (non-power-of-2 legal).
//    Separate occupancy count 0..DEPTH.
//    out_valid = (count != 0), registered. Bits driven from head entry.
//    Latency in->out = 1 cycle minimum; no combinational in->out path.
//    in_ready = (count < DEPTH) | (PIPE & count == DEPTH & out fire).
//    Simultaneous enq+deq: count unchanged, both ptrs advance.
//    Empty: enq only; no bypass, out_valid rises the cycle after enq.
//  - DEPTH==0: out_valid = in_valid, in_ready = out_ready, bits wired through.
//  - A throttle: out_a_valid gated low while inflight == MAX_INFLIGHT;
//    A FIFO holds its head. in_a_ready is unaffected until the FIFO fills.
//  - inflight: +1 on out_a fire, -1 on out_d fire, unchanged if both.
//    Saturates at MAX_INFLIGHT, floors at 0 (D fire at 0 is a protocol error).
//    Error is ignored in RTL and flagged by an assertion.
//  - Per-channel valid stays high once asserted until fire (TL rule).
//    Head bits stay stable while valid & !ready.
// TESTING
//  1 A_DEPTH=2, out_a_ready=0, push 3 beats -> beats 1,2 accepted, in_a_ready=0
//    on beat 3, a_full=1.
//  2 Full FIFO, PIPE=1, out_a_ready=1 + in_a_valid=1 -> enq+deq same cycle,
//    count stays 2; PIPE=0 -> in_a_ready=0.
//  3 MAX_INFLIGHT=4, issue 4 Gets with no D -> inflight=4, out_a_valid=0
//    with 5th beat buffered; one D fire -> 5th issues next cycle.
//  4 A_DEPTH=3, stream 10 beats with random ready -> order and data preserved
//    across ptr wrap.
//  5 A_DEPTH=0/D_DEPTH=0 -> out bits equal in bits same cycle, ready mirrored.
//  6 reset_n low for 1 cycle with 2 beats buffered -> valids 0, counts and
//    inflight 0; next push emerges 1 cycle later.

Source files
------------

// File: rtl/tl_ul_channel_buffer_if.sv
// One TileLink-UL channel: valid/ready handshake plus a packed payload.
// The master drives valid and bits, and the slave drives ready.
interface tl_ul_channel_buffer_if #(
   parameter int W = 1
);
   logic         valid;
   logic         ready;
   logic [W-1:0] bits;

   modport master (output valid, output bits, input ready);
   modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/tl_ul_channel_buffer.sv
// TileLink-UL A/D channel buffer: per-channel FIFOs plus an outstanding-request
// counter that throttles A issue once MAX_INFLIGHT beats are unanswered.
module tl_ul_channel_buffer_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 2,
   parameter int PIPE  = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_bits,
   input  logic         hold,
   output logic         full
);
   generate
      if (DEPTH == 0) begin : g_pass
         // A beat is only accepted if it can leave in the same cycle.
         assign out_valid = reset_n & in_valid & ~hold;
         assign in_ready  = reset_n & out_ready & ~hold;
         assign out_bits  = in_bits;
         assign full      = 1'b0;
      end else begin : g_fifo
         localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
         localparam int CW = $clog2(DEPTH + 1);

         logic [W-1:0]  mem [DEPTH];
         logic [PW-1:0] wr_ptr_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [CW-1:0] count_reg;
         logic          enq;
         logic          deq;

         assign out_valid = reset_n & (count_reg != '0) & ~hold;
         assign deq       = out_valid & out_ready;
         assign full      = (count_reg == CW'(DEPTH));
         assign in_ready  = reset_n & ((count_reg < CW'(DEPTH)) | ((PIPE != 0) & full & deq));
         assign enq       = in_valid & in_ready;
         assign out_bits  = mem[rd_ptr_reg];

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               // Explicit wrap so non-power-of-two depths work.
               if (enq)
                  wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
               if (deq)
                  rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
               if (enq && !deq)
                  count_reg <= count_reg + CW'(1);
               else if (deq && !enq)
                  count_reg <= count_reg - CW'(1);
            end
         end

         always_ff @(posedge clock) begin
            if (enq)
               mem[wr_ptr_reg] <= in_bits;
         end
      end
   endgenerate
endmodule

module tl_ul_channel_buffer #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int SOURCE_W     = 4,
   parameter int SIZE_W       = 4,
   parameter int SINK_W       = 1,
   parameter int A_DEPTH      = 2,
   parameter int D_DEPTH      = 2,
   parameter int PIPE         = 1,
   parameter int MAX_INFLIGHT = 4,
   localparam int AW = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
   localparam int DW = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 1 + DATA_W + 1,
   localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   tl_ul_channel_buffer_if.slave  in_a,
   tl_ul_channel_buffer_if.master out_a,
   tl_ul_channel_buffer_if.slave  in_d,
   tl_ul_channel_buffer_if.master out_d,
   output logic [CW-1:0]          inflight,
   output logic                   a_full,
   output logic                   d_full
);
   logic [CW-1:0] inflight_reg;
   logic          throttle;
   logic          a_fire;
   logic          d_fire;

   assign throttle = (inflight_reg == CW'(MAX_INFLIGHT));
   assign a_fire   = out_a.valid & out_a.ready;
   assign d_fire   = out_d.valid & out_d.ready;
   assign inflight = inflight_reg;

   tl_ul_channel_buffer_fifo #(.W(AW), .DEPTH(A_DEPTH), .PIPE(PIPE)) u_a_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_a.valid),
      .in_ready  (in_a.ready),
      .in_bits   (in_a.bits),
      .out_valid (out_a.valid),
      .out_ready (out_a.ready),
      .out_bits  (out_a.bits),
      .hold      (throttle),
      .full      (a_full)
   );

   tl_ul_channel_buffer_fifo #(.W(DW), .DEPTH(D_DEPTH), .PIPE(PIPE)) u_d_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_d.valid),
      .in_ready  (in_d.ready),
      .in_bits   (in_d.bits),
      .out_valid (out_d.valid),
      .out_ready (out_d.ready),
      .out_bits  (out_d.bits),
      .hold      (1'b0),
      .full      (d_full)
   );

   always_ff @(posedge clock) begin
      if (!reset_n)
         inflight_reg <= '0;
      else if (a_fire && !d_fire && !throttle)
         inflight_reg <= inflight_reg + CW'(1);
      else if (d_fire && !a_fire && inflight_reg != '0)
         inflight_reg <= inflight_reg - CW'(1);
   end

   // A response with nothing outstanding is a protocol violation upstream.
   assert property (@(posedge clock) disable iff (!reset_n)
      !(d_fire && !a_fire && inflight_reg == '0));
endmodule
